// File: rtl/clkdiv_pkg.sv
// Shared constants and the channel-index width helper for the clk_div_bank family.
package clkdiv_pkg;

    localparam int CLKDIV_CW          = 27;
    localparam int CLKDIV_DEFAULT_DIV = 50;

    // Channel index needs at least one bit even for a single-channel bank.
    function automatic int clkdiv_chw(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One clock-enable channel: period counter, square-wave/tick outputs and a
// pending divisor that is applied only at the channel's own period boundary.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CW          = CLKDIV_CW,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_sync,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wdiv,
    output logic          o_clk_out,
    output logic          o_tick,
    output logic          o_pend
);

    logic [CW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_pdiv;
    logic          r_pend;
    logic          r_clk;
    logic          r_tick;
    logic          w_stopped;
    logic          w_wrap;

    assign w_stopped = (r_div == '0);
    assign w_wrap    = !w_stopped && (r_cnt == r_div - CW'(1));

    // Stage p0: counter, outputs and divisor hand-over share one register stage.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div  <= CW'(DEFAULT_DIV);
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            if (i_sync || w_stopped) begin
                // A stopped channel and a sync pulse both park at phase zero and take any pending divisor.
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                if (r_pend) begin
                    r_div  <= r_pdiv;
                    r_pend <= 1'b0;
                end
            end else if (w_wrap) begin
                r_cnt <= '0;
                if (r_pend && (r_pdiv == '0)) begin
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else begin
                    r_clk  <= ~r_clk;
                    r_tick <= 1'b1;
                end
                if (r_pend) begin
                    r_div  <= r_pdiv;
                    r_pend <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_tick <= 1'b0;
            end
            // Writes are only strobed while not pending, so this never races the apply above.
            if (i_wr) begin
                r_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_pdiv <= i_wdiv;
        end
    end

    assign o_clk_out = r_clk;
    assign o_tick    = r_tick;
    assign o_pend    = r_pend;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-enable generator with valid/ready divisor loading.
// Define CLKDIV_SYNC_EN to add the 'sync' input that phase-aligns every channel.
module clk_div_bank
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CW          = CLKDIV_CW,
    parameter  int DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
    localparam int CHW         = clkdiv_chw(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst_n,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [CW-1:0]     cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic              w_sync;
    logic              w_busy;
    logic [NUM_CH-1:0] w_wr;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range channel indices match no strobe: always ready, write dropped.
    always_comb begin
        w_busy = 1'b0;
        w_wr   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                w_busy = pending[i];
            end
        end
        cfg_ready = rst_n & ~w_busy;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = cfg_valid & cfg_ready & (cfg_ch == CHW'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk     (clk_in),
            .i_rst_n   (rst_n),
            .i_sync    (w_sync),
            .i_wr      (w_wr[g]),
            .i_wdiv    (cfg_div),
            .o_clk_out (clk_out[g]),
            .o_tick    (tick[g]),
            .o_pend    (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: 4 channels, reset divisor 4, hand-derived tick/clk_out schedule.
module tb_clk_div_bank;

    localparam int NUM_CH = 4;
    localparam int CW     = 8;
    localparam int DEF    = 4;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [CW-1:0]     cfg_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;
`ifdef CLKDIV_SYNC_EN
    logic              sync;
`endif

    int total = 0;
    int bad   = 0;
    int e     = 0;
    int d    [NUM_CH];
    int base [NUM_CH];

    always #5 clk_in = ~clk_in;

    clk_div_bank #(
        .NUM_CH      (NUM_CH),
        .CW          (CW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
`ifdef CLKDIV_SYNC_EN
        .sync      (sync),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        e++;
    endtask

    // Channel with divisor d restarted at edge base: ticks every d edges after base,
    // clk_out low for the first d edges after base then alternating.
    task automatic check_model();
        logic [NUM_CH-1:0] et;
        logic [NUM_CH-1:0] ec;
        et = '0;
        ec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (d[i] != 0 && e > base[i]) begin
                et[i] = ((e - base[i]) % d[i]) == 0;
                ec[i] = (((e - base[i]) / d[i]) % 2) == 1;
            end
        end
        check($sformatf("tick@%0d", e), {28'b0, tick}, {28'b0, et});
        check($sformatf("clk_out@%0d", e), {28'b0, clk_out}, {28'b0, ec});
    endtask

    task automatic run_to(input int t);
        while (e < t) begin
            step();
            check_model();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = '0;
`ifdef CLKDIV_SYNC_EN
        sync      = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            d[i]    = DEF;
            base[i] = 0;
        end

        step();
        step();
        check("rst_tick", {28'b0, tick}, 32'h0);
        check("rst_clk_out", {28'b0, clk_out}, 32'h0);
        check("rst_pending", {28'b0, pending}, 32'h0);
        check("rst_ready", {31'b0, cfg_ready}, 32'h0);

        e = 0;
        rst_n = 1'b1;
        #1;
        check("ready_after_release", {31'b0, cfg_ready}, 32'h1);
        run_to(13);

        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
        #1;
        check("ready_ch1", {31'b0, cfg_ready}, 32'h1);
        step(); check_model();
        check("pend_ch1", {28'b0, pending}, 32'h2);

        cfg_ch = 2'd1; cfg_div = 8'd7;
        #1;
        check("stall_ch1", {31'b0, cfg_ready}, 32'h0);
        cfg_ch = 2'd2; cfg_div = 8'd2;
        #1;
        check("ready_ch2", {31'b0, cfg_ready}, 32'h1);
        step(); check_model();
        cfg_valid = 1'b0;
        check("pend_ch1_ch2", {28'b0, pending}, 32'h6);

        step(); check_model();
        check("applied_16", {28'b0, pending}, 32'h0);
        d[1] = 3; d[2] = 2;
        for (int i = 0; i < NUM_CH; i++) base[i] = 16;
        run_to(29);

        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
        #1;
        check("ready_ch0_stop", {31'b0, cfg_ready}, 32'h1);
        step(); check_model();
        cfg_valid = 1'b0;
        check("pend_ch0_stop", {28'b0, pending}, 32'h1);
        run_to(31);
        d[0] = 0;
        step(); check_model();
        check("applied_stop", {28'b0, pending}, 32'h0);
        run_to(34);

        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
        #1;
        check("ready_ch0_d1", {31'b0, cfg_ready}, 32'h1);
        step(); check_model();
        cfg_valid = 1'b0;
        check("pend_ch0_d1", {28'b0, pending}, 32'h1);
        d[0] = 1; base[0] = 36;
        step(); check_model();
        check("applied_d1", {28'b0, pending}, 32'h0);
        run_to(41);

        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
        #1;
        check("ready_ch3", {31'b0, cfg_ready}, 32'h1);
        step(); check_model();
        cfg_valid = 1'b0;
        check("pend_ch3", {28'b0, pending}, 32'h8);
        rst_n = 1'b0; cfg_ch = 2'd0;
        #1;
        check("ready_in_reset", {31'b0, cfg_ready}, 32'h0);
        for (int i = 0; i < NUM_CH; i++) begin
            d[i] = DEF; base[i] = 43;
        end
        step(); check_model();
        check("pend_cleared_by_reset", {28'b0, pending}, 32'h0);
        rst_n = 1'b1;
        run_to(55);

`ifdef CLKDIV_SYNC_EN
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        step(); check_model();
        cfg_ch = 2'd1; cfg_div = 8'd7;
        #1;
        check("ready_ch1_sync", {31'b0, cfg_ready}, 32'h1);
        step(); check_model();
        cfg_valid = 1'b0;
        check("pend_before_sync", {28'b0, pending}, 32'h3);
        sync = 1'b1;
        d[0] = 5; d[1] = 7;
        for (int i = 0; i < NUM_CH; i++) base[i] = 58;
        step();
        sync = 1'b0;
        check_model();
        check("pend_after_sync", {28'b0, pending}, 32'h0);
        run_to(72);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable generator, the parametrised successor to the fixed divide-by-100 divider. It produces `NUM_CH` independent divided square waves plus single-cycle tick enables from one `clk_in`, each channel with a run-time divisor loaded through a valid/ready config port. Divisor changes are glitch-free: they take effect only at the channel's period boundary. The block sits between the board clock and the timing consumers (display refresh, debounce, stopwatch, blink), which must use `tick` as a clock enable, never as a clock.

## Interface
- `NUM_CH`, 4: number of channels, 1..16
- `CW`, 27: divisor/counter width in bits
- `DEFAULT_DIV`, 50: divisor loaded into every channel at reset, must fit in `CW`
- `CHW`, `$clog2(NUM_CH)` (min 1): channel-index width, derived and not overridable

- `clk_in` in 1: single clock; all logic on its rising edge
- `rst_n` in 1: synchronous, active-low reset
- `cfg_valid` in 1: config request
- `cfg_ready` out 1: config accepted when `cfg_valid & cfg_ready`
- `cfg_ch` in `CHW`: target channel
- `cfg_div` in `CW`: new divisor D; 0 stops the channel
- `clk_out` out `NUM_CH`: divided square wave per channel, registered
- `tick` out `NUM_CH`: period strobe per channel, registered
- `pending` out `NUM_CH`: channel has an accepted, not yet applied divisor

## Operation
- Per channel: registers `div`, `cnt`, `pdiv` and `pend`.
- Counting, when `div` ≥ 1: `cnt` counts 0..D-1.
  - On the edge where `cnt == D-1`: `cnt` ← 0, `tick` ← 1, `clk_out` ← ~`clk_out`.
  - On every other edge: `cnt` ← `cnt`+1, `tick` ← 0.
- Resulting rates: `tick` period is D cycles; `clk_out` period is 2D cycles at 50% duty.
- D = 1: `tick` is constantly 1 and `clk_out` toggles every cycle.
- D = 0: channel is stopped. `cnt`, `tick` and `clk_out` are held at 0.
- Config handshake:
  - `cfg_ready` = `rst_n & ~pend[cfg_ch]` (combinational on `cfg_ch`).
  - On acceptance: `pdiv[cfg_ch]` ← `cfg_div`, `pend` ← 1.
  - If `cfg_ch` ≥ `NUM_CH`: `cfg_ready` = 1 and the write is dropped.
- Apply: on the first wrap edge after acceptance (`cnt == D-1`), `div` ← `pdiv`, `cnt` ← 0, `pend` ← 0.
  - That same edge still produces the old period's tick/toggle.
  - If the channel is stopped (D = 0), apply happens on the edge after acceptance. Counting then restarts from `cnt` = 0 with `clk_out` = 0.
- Applying D = 0: `clk_out` ← 0 and `tick` ← 0 on the apply edge.
- Arithmetic: unsigned, `CW` bits. The compare uses `div`-1 only when `div` ≠ 0. The counter never exceeds `div`-1, so it cannot wrap.

## Timing
- Reset, `rst_n` = 0 at an edge:
  - `cnt` = 0, `div` = `DEFAULT_DIV`, `pend` = 0
  - `clk_out` = 0, `tick` = 0
  - `cfg_ready` = 0 while `rst_n` is low
  - Reset mid-period discards the partial period and any pending divisor.
- After release, for D ≥ 1: the first `tick`/`clk_out` rise is visible after the D-th edge with `rst_n` high.
- Config latency:
  - `pending` rises the edge after acceptance.
  - The new divisor applies at the next wrap of the old period, at most D_old edges later.
- Acceptance on the same edge as a wrap: the write is captured but is not applied on that wrap. It applies at the following wrap.
- Simultaneous requests cannot occur: there is one config port, and channels are independent.

## Configuration
- `CLKDIV_SYNC_EN` defined: adds input `sync` (1 bit).
  - When `sync` = 1 at an edge, every channel sets `cnt` ← 0, `tick` ← 0, `clk_out` ← 0.
  - Any pending divisor applies immediately (`pend` ← 0). This phase-aligns all outputs.
  - `sync` has lower priority than `rst_n`.
- `CLKDIV_SYNC_EN` not defined: no `sync` port; behaviour is identical to `sync` tied to 0.

## Structure
- Package `clkdiv_pkg`: default `CW`/`DEFAULT_DIV` constants and the `CHW` derivation function.
- One sub-module, `clkdiv_channel`: holds `div`/`cnt`/`pdiv`/`pend`, the wrap logic and the outputs.
- Top level: instantiates `NUM_CH` copies via generate, decodes `cfg_ch` to per-channel write strobes, and muxes `cfg_ready`.

## Test plan
- Reset defaults: `NUM_CH` = 4, `DEFAULT_DIV` = 4 → every `tick` pulses on edges 4, 8, 12…; `clk_out` period 8 cycles; `pending` = 0.
- Load and apply: load ch1 D = 3 mid-period → `pending[1]` = 1 until the next old wrap; afterwards ticks every 3 cycles, with no short or long `clk_out` phase across the change.
- Handshake stall: second write to ch1 while pending → `cfg_ready` = 0; a write to ch2 in the same window is accepted.
- Stop and restart: load D = 0 on ch0 → `clk_out[0]` = `tick[0]` = 0 held. Then load D = 1 → applies the next edge; `tick[0]` constantly 1 and `clk_out[0]` toggles every cycle.
- Mid-period reset: assert `rst_n` = 0 for one edge at `cnt` = 2 with a pending write → all outputs 0, pending cleared, `div` = `DEFAULT_DIV`.
- With `CLKDIV_SYNC_EN`: channels at D = 5 and D = 7, pulse `sync` → both `clk_out` = 0 the next cycle; first ticks arrive 5 and 7 edges later.
